fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It holds the program counter and issues word requests to instruction memory over a valid/ready handshake. Returned words are buffered in an in-order FIFO and presented to decode, whose instruction field feeds the immediate sign-extension logic. Control-flow redirects flush all in-flight and buffered fetches.

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, credit-limited request issue to
// instruction memory, in-order instruction buffer towards decode, and
// redirect handling that drops stale in-flight responses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready in the same cycle. The response
// channel has no ready and is always accepted. Responses return in request
// order.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Instruction memory request channel
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  // Instruction memory response channel
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  // Control-flow redirect
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  // Decode channel
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Counters must be able to hold the value FIFO_DEPTH itself.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  started_q;

  // Instruction buffer: word and its fetch address per entry.
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;

  // Addresses of issued-but-unanswered requests, used to tag responses.
  // Outstanding requests never exceed FIFO_DEPTH, so this cannot overflow.
  logic [ADDR_WIDTH-1:0] tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      tag_wr_q, tag_rd_q;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] inflight;
  logic           req_fire;
  logic           rsp_fire;
  logic           push;
  logic           pop;
  logic           unused_redirect_lsb;

  // Word alignment discards the low two redirect bits.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign inflight = {1'b0, count_q} + {1'b0, outst_q};

  // Request valid is a function of registered state only.
  assign imem_req_valid = started_q && (inflight < DEPTH_C) && (drop_q == '0);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset)
  // are ignored entirely.
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);

  // A response is buffered only when it is not stale: no pending drops and
  // no redirect arriving in the same cycle.
  assign push = rsp_fire && (drop_q == '0) && !redirect_valid;

  // A pop coinciding with a redirect is ignored; the buffer is flushed anyway.
  assign pop = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic for PC, counters and buffer pointers
  // ---------------------------------------------------------------------------
  // Next-state computation; redirect overrides normal sequencing.
  always_comb begin
    pc_d     = pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    // Outstanding tracks every accepted request until its response returns,
    // stale or not.
    case ({req_fire, rsp_fire})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (req_fire) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end

    if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      // Everything still in flight after this edge is stale. A same-cycle
      // response already left outst_d, a same-cycle request is included.
      drop_d   = outst_d;
      count_d  = '0;
      // Realign the read pointer so the emptied buffer starts cleanly.
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // Control registers: PC, counters, pointers and the start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      started_q <= 1'b1;
      if (req_fire) begin
        tag_wr_q <= tag_wr_q + 1'b1;
      end
      if (rsp_fire) begin
        tag_rd_q <= tag_rd_q + 1'b1;
      end
    end
  end

  // Storage arrays: buffered words, their addresses and the request tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      if (req_fire) begin
        tag_q[tag_wr_q] <= pc_q;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= imem_rsp_data;
        fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a simple in-order memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks;
  int errors;

  // Memory model controls
  int          cyc;
  int          mem_lat;
  int          hs_count;
  bit          inject;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(2),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: returns word = address, mem_lat cycles after the handshake.
  // inject forces a spurious response word for one cycle.
  initial begin
    cyc            = 0;
    hs_count       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat - 1);
        hs_count = hs_count + 1;
      end
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (inject) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (rst_n && mq_due.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq_addr.pop_front();
        void'(mq_due.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Assert reset for two cycles and release it at a falling edge.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inject         = 1'b0;
    mem_lat        = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Consume n instructions in order starting at start_pc (decode ready held
  // high by the caller); returns at the falling edge of the last one.
  task automatic collect(input logic [31:0] start_pc, input int n);
    logic [31:0] exp_pc;
    int got;
    int waited;
    exp_pc = start_pc;
    got    = 0;
    waited = 0;
    while (got < n && waited < 200) begin
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc) begin
          errors++;
          $display("FAIL collect_pc: instr_pc=%h expected %h", instr_pc, exp_pc);
        end
        checks++;
        if (instr !== exp_pc) begin
          errors++;
          $display("FAIL collect_data: instr=%h expected %h", instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      if (got < n) begin
        @(negedge clk);
        waited++;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL collect_timeout: got %0d instructions expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inject         = 1'b0;
    mem_lat        = 1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid);
    end
    checks++;
    if (instr !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h expected 00000000", instr);
    end
    checks++;
    if (instr_pc !== 32'h0) begin
      errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc);
    end
  endtask

  // Straight-line fetch; a spurious response before the first request is
  // ignored.
  task automatic test_straight();
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL straight_first_req: valid=%b addr=%h expected 1/00000000",
               imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL straight_spurious: instr_valid=%b expected 0", instr_valid);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL straight_latency: instr_valid=%b expected 1", instr_valid);
    end
    collect(32'h0, 6);
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_head: valid=%b pc=%h expected 1/00000000", instr_valid, instr_pc);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_req_blocked: req_valid=%b expected 0", imem_req_valid);
    end
    instr_ready = 1'b1;
    collect(32'h0, 5);
  endtask

  task automatic test_mem_stall();
    do_reset();
    collect(32'h0, 2);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      errors++;
      $display("FAIL stall_start: valid=%b addr=%h expected 1/00000008",
               imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%h expected 1/00000008",
                 imem_req_valid, imem_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    collect(32'h8, 3);
  endtask

  // Redirect while two requests are outstanding; both words must be dropped.
  task automatic test_redirect_outstanding();
    int base;
    int w;
    do_reset();
    mem_lat = 4;
    base    = hs_count;
    w       = 0;
    while (hs_count - base < 2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (hs_count - base != 2 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_setup: handshakes=%0d req_valid=%b expected 2/0",
               hs_count - base, imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_after: instr_valid=%b req_valid=%b expected 0/0",
               instr_valid, imem_req_valid);
    end
    collect(32'h100, 3);
  endtask

  // Redirect in the same cycle as a response and a request handshake.
  task automatic test_redirect_collide();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      errors++;
      $display("FAIL collide_setup: rsp=%b req=%b addr=%h expected 1/1/00000004",
               imem_rsp_valid, imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL collide_no_stale: instr_valid=%b expected 0", instr_valid);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL collide_drop_wait: req_valid=%b expected 0", imem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL collide_resume: valid=%b addr=%h expected 1/00000200",
               imem_req_valid, imem_req_addr);
    end
    collect(32'h200, 4);
  endtask

  // Asynchronous reset with a full buffer, then restart from RESET_PC.
  task automatic test_reset_async();
    do_reset();
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_full: instr_valid=%b req_valid=%b expected 1/0",
               instr_valid, imem_req_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_req: valid=%b addr=%h expected 0/00000000",
               imem_req_valid, imem_req_addr);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_instr: valid=%b instr=%h pc=%h expected 0/00000000/00000000",
               instr_valid, instr, instr_pc);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_restart: valid=%b addr=%h expected 1/00000000",
               imem_req_valid, imem_req_addr);
    end
    collect(32'h0, 3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_straight();
    test_backpressure();
    test_mem_stall();
    test_redirect_outstanding();
    test_redirect_collide();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
